pc_sequencer: RTL and testbench

Multi-cycle fetch/execute sequencer that owns the program counter of the processor core. It issues instruction-memory reads and holds the PC while the instruction and data memories assert busywait. It resolves jump/branch decisions from decoder and ALU flags, then commits the next PC (PC+4 or the sign-extended word-offset target). It sits between the control unit, the ALU ZERO flag and both memory handshakes.

---
 rtl/pc_sequencer_pkg.sv | 11 +
 rtl/pc_sequencer_if.sv | 30 +++
 rtl/pc_sequencer_branch_target_calc.sv | 18 +
 rtl/pc_sequencer.sv | 68 ++++++
 tb/tb_pc_sequencer.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared state encoding, defaults and branch decision for pc_sequencer
package pc_sequencer_pkg;
  typedef enum logic {FETCH = 1'b0, EXEC = 1'b1} state_e;
  localparam logic [31:0] PC_INC_DEF = 32'd4;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam int OFFSET_W = 8;
  // JUMP together with BRANCH is illegal and resolves as not taken
  function automatic logic is_taken(input logic jump, input logic branch, input logic bne, input logic zero);
    return (jump & ~branch) | (branch & ~jump & (bne ^ zero));
  endfunction
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: memory handshakes, decoder/ALU flags and PC outputs of pc_sequencer
// master: sequencer side (drives IMEM_READ, PC, INSTR_VALID, ILLEGAL and, with
// PC_SEQ_PERF_CNT_EN, TAKEN_CNT/STALL_CNT); slave: environment side
interface pc_sequencer_if;
  import pc_sequencer_pkg::*;
  logic IMEM_BUSYWAIT;
  logic IMEM_READ;
  logic [31:0] PC;
  logic INSTR_VALID;
  logic JUMP;
  logic BRANCH;
  logic BNE;
  logic ZERO;
  logic [OFFSET_W-1:0] OFFSET;
  logic DMEM_BUSYWAIT;
  logic ILLEGAL;
`ifdef PC_SEQ_PERF_CNT_EN
  logic [15:0] TAKEN_CNT;
  logic [15:0] STALL_CNT;
  modport master(input IMEM_BUSYWAIT, JUMP, BRANCH, BNE, ZERO, OFFSET, DMEM_BUSYWAIT,
                 output IMEM_READ, PC, INSTR_VALID, ILLEGAL, TAKEN_CNT, STALL_CNT);
  modport slave(output IMEM_BUSYWAIT, JUMP, BRANCH, BNE, ZERO, OFFSET, DMEM_BUSYWAIT,
                input IMEM_READ, PC, INSTR_VALID, ILLEGAL, TAKEN_CNT, STALL_CNT);
`else
  modport master(input IMEM_BUSYWAIT, JUMP, BRANCH, BNE, ZERO, OFFSET, DMEM_BUSYWAIT,
                 output IMEM_READ, PC, INSTR_VALID, ILLEGAL);
  modport slave(output IMEM_BUSYWAIT, JUMP, BRANCH, BNE, ZERO, OFFSET, DMEM_BUSYWAIT,
                input IMEM_READ, PC, INSTR_VALID, ILLEGAL);
`endif
endinterface

// File: rtl/pc_sequencer_branch_target_calc.sv
// branch_target_calc: combinational next-PC select between PC+PC_INC and word-offset target
// pc: current PC; offset: signed word offset; taken: branch decision; next_pc: committed PC
module branch_target_calc
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] PC_INC = PC_INC_DEF
) (
  input  logic [31:0]         pc,
  input  logic [OFFSET_W-1:0] offset,
  input  logic                taken,
  output logic [31:0]         next_pc
);
  logic [31:0] seq_pc;
  always_comb begin
    seq_pc = pc + PC_INC;
    next_pc = taken ? seq_pc + {{(30-OFFSET_W){offset[OFFSET_W-1]}}, offset, 2'b00} : seq_pc;
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: two-state fetch/execute sequencer owning the program counter
// CLK: clock; RESET: async active-low reset; bus: pc_sequencer_if.master
// Optional macro PC_SEQ_PERF_CNT_EN adds saturating TAKEN_CNT/STALL_CNT counters
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [31:0] PC_INC = PC_INC_DEF
) (
  input logic           CLK,
  input logic           RESET,
  pc_sequencer_if.master bus
);
  state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, next_pc;
  logic taken, commit;
  assign taken = is_taken(bus.JUMP, bus.BRANCH, bus.BNE, bus.ZERO);
  // flags are only looked at on the EXEC edge where data memory is idle
  assign commit = (state_q == EXEC) && !bus.DMEM_BUSYWAIT;
  branch_target_calc #(.PC_INC(PC_INC)) u_btc (
    .pc(pc_q),
    .offset(bus.OFFSET),
    .taken(taken),
    .next_pc(next_pc)
  );
  always_comb begin
    state_d = state_q;
    pc_d = commit ? next_pc : pc_q;
    if (state_q == FETCH) begin
      if (!bus.IMEM_BUSYWAIT) state_d = EXEC;
    end else if (commit) begin
      state_d = FETCH;
    end
  end
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= FETCH;
      pc_q <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
    end
  end
  assign bus.PC = pc_q;
  assign bus.IMEM_READ = RESET && (state_q == FETCH);
  assign bus.INSTR_VALID = RESET && (state_q == EXEC);
  assign bus.ILLEGAL = RESET && commit && bus.JUMP && bus.BRANCH;
`ifdef PC_SEQ_PERF_CNT_EN
  logic [15:0] taken_cnt_q, taken_cnt_d, stall_cnt_q, stall_cnt_d;
  logic stall;
  always_comb begin
    stall = (state_q == FETCH) ? bus.IMEM_BUSYWAIT : bus.DMEM_BUSYWAIT;
    taken_cnt_d = taken_cnt_q + 16'((commit && taken && taken_cnt_q != 16'hFFFF) ? 1 : 0);
    stall_cnt_d = stall_cnt_q + 16'((stall && stall_cnt_q != 16'hFFFF) ? 1 : 0);
  end
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      taken_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      taken_cnt_q <= taken_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign bus.TAKEN_CNT = taken_cnt_q;
  assign bus.STALL_CNT = stall_cnt_q;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed plus randomized instruction-level check of pc_sequencer
module tb_pc_sequencer;
  logic clk = 0;
  logic rst_n = 0;
  int checks = 0;
  int errors = 0;
  logic [31:0] mpc = 0;
  int m_taken = 0;
  int m_stall = 0;
  pc_sequencer_if bus();
  pc_sequencer dut (.CLK(clk), .RESET(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // one instruction: fs fetch stall cycles, es exec stall cycles, then commit with the given flags
  task automatic run_instr(input int fs, input int es, input bit j, input bit b, input bit n, input bit z, input logic [7:0] off);
    bit tk;
    int d;
    for (int i = 0; i <= fs; i++) begin
      bus.IMEM_BUSYWAIT = (i < fs);
      bus.DMEM_BUSYWAIT = 1'($urandom);
      {bus.JUMP, bus.BRANCH, bus.BNE, bus.ZERO} = 4'($urandom);
      bus.OFFSET = 8'($urandom);
      @(negedge clk);
      check("fetch_read", 32'(bus.IMEM_READ), 32'd1);
      check("fetch_valid", 32'(bus.INSTR_VALID), 32'd0);
      check("fetch_illegal", 32'(bus.ILLEGAL), 32'd0);
      check("fetch_pc", bus.PC, mpc);
      @(posedge clk); #1;
    end
    m_stall += fs;
    for (int i = 0; i < es; i++) begin
      bus.DMEM_BUSYWAIT = 1;
      bus.IMEM_BUSYWAIT = 1'($urandom);
      {bus.JUMP, bus.BRANCH, bus.BNE, bus.ZERO} = 4'($urandom);
      bus.OFFSET = 8'($urandom);
      @(negedge clk);
      check("stall_valid", 32'(bus.INSTR_VALID), 32'd1);
      check("stall_read", 32'(bus.IMEM_READ), 32'd0);
      check("stall_illegal", 32'(bus.ILLEGAL), 32'd0);
      check("stall_pc", bus.PC, mpc);
      @(posedge clk); #1;
    end
    m_stall += es;
    bus.DMEM_BUSYWAIT = 0;
    bus.IMEM_BUSYWAIT = 1'($urandom);
    {bus.JUMP, bus.BRANCH, bus.BNE, bus.ZERO} = {j, b, n, z};
    bus.OFFSET = off;
    @(negedge clk);
    check("exec_valid", 32'(bus.INSTR_VALID), 32'd1);
    check("exec_illegal", 32'(bus.ILLEGAL), 32'(j & b));
    check("exec_pc", bus.PC, mpc);
    @(posedge clk); #1;
    tk = (j && !b) || (b && !j && (n != z));
    d = tk ? int'($signed(off)) * 4 : 0;
    mpc = mpc + 32'd4 + 32'(d);
    m_taken += int'(tk);
  endtask
  initial begin
    bus.IMEM_BUSYWAIT = 0;
    bus.DMEM_BUSYWAIT = 0;
    bus.JUMP = 0;
    bus.BRANCH = 0;
    bus.BNE = 0;
    bus.ZERO = 0;
    bus.OFFSET = 0;
    #12;
    check("rst_pc", bus.PC, 32'h0);
    check("rst_read", 32'(bus.IMEM_READ), 32'd0);
    check("rst_valid", 32'(bus.INSTR_VALID), 32'd0);
    check("rst_illegal", 32'(bus.ILLEGAL), 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    run_instr(0, 0, 0, 0, 0, 0, 8'h00);
    check("seq1", mpc, 32'h4);
    run_instr(0, 0, 0, 0, 0, 0, 8'h00);
    run_instr(0, 0, 1, 0, 0, 0, 8'h01);
    check("jmp_0x10", bus.PC, 32'h10);
    run_instr(0, 0, 0, 1, 0, 1, 8'hFE);
    check("beq_taken", bus.PC, 32'h0C);
    run_instr(0, 0, 1, 0, 0, 0, 8'h00);
    run_instr(0, 0, 0, 1, 0, 0, 8'hFE);
    check("beq_not", bus.PC, 32'h14);
    run_instr(0, 0, 1, 0, 0, 0, 8'hFE);
    run_instr(0, 0, 0, 1, 1, 1, 8'hFE);
    check("bne_not", bus.PC, 32'h14);
    run_instr(0, 0, 1, 0, 0, 0, 8'hFE);
    run_instr(0, 0, 0, 1, 1, 0, 8'hFE);
    check("bne_taken", bus.PC, 32'h0C);
    run_instr(0, 0, 1, 0, 0, 0, 8'h04);
    check("jmp_0x20", bus.PC, 32'h20);
    run_instr(0, 0, 1, 0, 0, 0, 8'h03);
    check("jmp_0x30", bus.PC, 32'h30);
    run_instr(0, 0, 1, 1, 0, 1, 8'h05);
    check("illegal_pc", bus.PC, 32'h34);
    run_instr(0, 0, 1, 0, 0, 0, 8'hF2);
    check("jmp_zero", bus.PC, 32'h0);
    run_instr(0, 0, 1, 0, 0, 0, 8'hFE);
    check("jmp_top", bus.PC, 32'hFFFF_FFFC);
    run_instr(0, 0, 0, 0, 0, 0, 8'h00);
    check("wrap", bus.PC, 32'h0);
    run_instr(3, 0, 0, 0, 0, 0, 8'h00);
    run_instr(0, 2, 1, 0, 0, 0, 8'h02);
    check("stall_jmp", bus.PC, 32'h10);
`ifdef PC_SEQ_PERF_CNT_EN
    check("taken_cnt", 32'(bus.TAKEN_CNT), 32'(m_taken));
    check("stall_cnt", 32'(bus.STALL_CNT), 32'(m_stall));
`endif
    bus.IMEM_BUSYWAIT = 0;
    @(posedge clk); #1;
    bus.DMEM_BUSYWAIT = 1;
    bus.JUMP = 1;
    bus.BRANCH = 0;
    bus.OFFSET = 8'h05;
    #2;
    check("mid_valid_pre", 32'(bus.INSTR_VALID), 32'd1);
    rst_n = 0;
    #1;
    check("mid_pc", bus.PC, 32'h0);
    check("mid_valid", 32'(bus.INSTR_VALID), 32'd0);
    check("mid_illegal", 32'(bus.ILLEGAL), 32'd0);
    check("mid_read", 32'(bus.IMEM_READ), 32'd0);
`ifdef PC_SEQ_PERF_CNT_EN
    check("mid_taken_cnt", 32'(bus.TAKEN_CNT), 32'd0);
    check("mid_stall_cnt", 32'(bus.STALL_CNT), 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1;
    mpc = 0;
    m_taken = 0;
    m_stall = 0;
    bus.DMEM_BUSYWAIT = 0;
    bus.JUMP = 0;
    run_instr(0, 0, 0, 0, 0, 0, 8'h00);
    check("post_rst", bus.PC, 32'h4);
    for (int k = 0; k < 300; k++)
      run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), 8'($urandom));
`ifdef PC_SEQ_PERF_CNT_EN
    check("final_taken_cnt", 32'(bus.TAKEN_CNT), 32'(m_taken));
    check("final_stall_cnt", 32'(bus.STALL_CNT), 32'(m_stall));
`endif
    check("final_pc", bus.PC, mpc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
